// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NREQ requesters, 2-cycle latency.
// Optional ALU_ARB_LOCK_EN lets a granted requester hold the ALU for up to LOCK_MAX transfers.
module alu_arbiter #(
    parameter int NREQ = 2,
    parameter int BUS = 4,
    parameter int LOCK_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*BUS-1:0] req_opa,
    input  logic [NREQ*BUS-1:0] req_opb,
    input  logic [NREQ*2-1:0]   req_funtype,
    input  logic [NREQ*2-1:0]   req_funcode,
    input  logic [NREQ*2-1:0]   req_kernelsel,
    input  logic [NREQ-1:0]     req_lock,
    output logic [BUS-1:0]      alu_opa,
    output logic [BUS-1:0]      alu_opb,
    output logic [1:0]          alu_kernelsel,
    output logic [1:0]          alu_funtype,
    output logic [1:0]          alu_funcode,
    input  logic [BUS-1:0]      alu_result,
    input  logic [3:0]          alu_cpsr,
    output logic [NREQ-1:0]     rsp_valid,
    output logic [BUS-1:0]      rsp_result,
    output logic [3:0]          rsp_cpsr,
    output logic                busy
);
    logic [1:0] ptr, gi, pos, nxt, iss_id;
    logic [3:0] vld;
    logic       found, xfer, iss_v;

    assign vld = 4'(req_valid);
`ifdef ALU_ARB_LOCK_EN
    logic       lock_act;
    logic [1:0] owner;
    logic [7:0] cnt;
    logic [3:0] lk;
    assign lk = 4'(req_lock);
`else
    logic unused_lock;
    assign unused_lock = ^req_lock ^ (LOCK_MAX > 0);
`endif

    always_comb begin
        found = 1'b0;
        gi = '0;
        pos = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = 2'((int'(ptr) + k) % NREQ);
            if (!found && vld[pos]) begin
                found = 1'b1;
                gi = pos;
            end
        end
`ifdef ALU_ARB_LOCK_EN
        if (lock_act && vld[owner] && lk[owner]) begin
            found = 1'b1;
            gi = owner;
        end
`endif
        req_ready = (found && !rst) ? NREQ'(1) << gi : '0;
    end

    assign xfer = |req_ready;
    assign nxt = 2'((int'(gi) + 1) % NREQ);
    assign busy = iss_v | (|rsp_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            iss_v <= 1'b0;
            iss_id <= '0;
            alu_opa <= '0;
            alu_opb <= '0;
            alu_kernelsel <= '0;
            alu_funtype <= '0;
            alu_funcode <= '0;
            rsp_valid <= '0;
            rsp_result <= '0;
            rsp_cpsr <= '0;
`ifdef ALU_ARB_LOCK_EN
            lock_act <= 1'b0;
            owner <= '0;
            cnt <= '0;
`endif
        end else begin
            iss_v <= xfer;
            if (xfer) begin
                iss_id <= gi;
                alu_opa <= req_opa[gi*BUS +: BUS];
                alu_opb <= req_opb[gi*BUS +: BUS];
                alu_kernelsel <= req_kernelsel[gi*2 +: 2];
                alu_funtype <= req_funtype[gi*2 +: 2];
                alu_funcode <= req_funcode[gi*2 +: 2];
            end
            rsp_valid <= iss_v ? NREQ'(1) << iss_id : '0;
            if (iss_v) begin
                rsp_result <= alu_result;
                rsp_cpsr <= alu_cpsr;
            end
`ifdef ALU_ARB_LOCK_EN
            // a locked transfer keeps the pointer; the LOCK_MAX-th one releases and advances it
            if (xfer && lk[gi] && int'(cnt) + 1 < LOCK_MAX) begin
                lock_act <= 1'b1;
                owner <= gi;
                cnt <= cnt + 8'd1;
            end else begin
                lock_act <= 1'b0;
                cnt <= '0;
                if (xfer) ptr <= nxt;
            end
`else
            if (xfer) ptr <= nxt;
`endif
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a behavioural 4-bit ALU attached.
module tb_alu_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_ready;
    logic [1:0] req_lock = '0;
    logic [3:0] opa [2];
    logic [3:0] opb [2];
    logic [1:0] ft [2];
    logic [1:0] fc [2];
    logic [1:0] ks [2];
    logic [3:0] alu_opa, alu_opb, alu_result, alu_cpsr, rsp_result, rsp_cpsr;
    logic [1:0] alu_kernelsel, alu_funtype, alu_funcode, rsp_valid;
    logic       busy;
    int n_chk = 0, n_fail = 0, cyc = 0;

    typedef struct {int id; logic [3:0] res; logic [3:0] cpsr; int due;} exp_t;
    exp_t q[$];

    function automatic logic [3:0] alu_f(logic [3:0] a, logic [3:0] b, logic [1:0] t, logic [1:0] c);
        if (t != 2'b00) return a ^ b;
        case (c)
            2'b00: return a + b;
            2'b01: return a - b;
            2'b10: return a & b;
            default: return a | b;
        endcase
    endfunction

    assign alu_result = alu_f(alu_opa, alu_opb, alu_funtype, alu_funcode);
    assign alu_cpsr = {alu_kernelsel, alu_funtype[0], alu_result == 4'd0};

    alu_arbiter #(.NREQ(2), .BUS(4), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_opa({opa[1], opa[0]}), .req_opb({opb[1], opb[0]}),
        .req_funtype({ft[1], ft[0]}), .req_funcode({fc[1], fc[0]}),
        .req_kernelsel({ks[1], ks[0]}), .req_lock(req_lock),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_kernelsel(alu_kernelsel),
        .alu_funtype(alu_funtype), .alu_funcode(alu_funcode),
        .alu_result(alu_result), .alu_cpsr(alu_cpsr),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_cpsr(rsp_cpsr), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: push on every observed transfer, pop on every response pulse
    always @(negedge clk) begin
        if (rst) q.delete();
        else begin
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i]) begin
                    logic [3:0] r;
                    r = alu_f(opa[i], opb[i], ft[i], fc[i]);
                    q.push_back('{i, r, {ks[i], ft[i][0], r == 4'd0}, cyc + 2});
                end
            n_chk++;
            if ($countones(req_ready) > 1) begin
                n_fail++;
                $display("FAIL ready_onehot: req_ready=%b", req_ready);
            end
            if (rsp_valid != 2'b00) begin
                n_chk++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: rsp_valid=%b at cycle %0d", rsp_valid, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (rsp_valid !== 2'(1 << e.id) || rsp_result !== e.res || rsp_cpsr !== e.cpsr || cyc != e.due) begin
                        n_fail++;
                        $display("FAIL rsp: got valid=%b res=%h cpsr=%b cyc=%0d, want valid=%b res=%h cpsr=%b cyc=%0d",
                                 rsp_valid, rsp_result, rsp_cpsr, cyc, 2'(1 << e.id), e.res, e.cpsr, e.due);
                    end
                end
            end
            if (q.size() > 0 && q[0].due < cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL rsp_missing: id=%0d due=%0d now=%0d", q[0].id, q[0].due, cyc);
                void'(q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [3:0] a, logic [3:0] b, logic [1:0] t, logic [1:0] c, logic [1:0] k);
        opa[i] = a; opb[i] = b; ft[i] = t; fc[i] = c; ks[i] = k;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        req_lock = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic expect_ready(string nm, logic [1:0] want);
        @(negedge clk);
        n_chk++;
        if (req_ready !== want) begin
            n_fail++;
            $display("FAIL %s: req_ready=%b want %b", nm, req_ready, want);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) set_req(i, 4'd0, 4'd0, 2'd0, 2'd0, 2'd0);
        rst = 1'b1;
        req_valid = 2'b11;
        step();
        @(negedge clk);
        n_chk++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_result !== 4'd0 || rsp_cpsr !== 4'd0 ||
            busy !== 1'b0 || alu_opa !== 4'd0 || alu_opb !== 4'd0 || alu_funcode !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rsp=%b res=%h cpsr=%h busy=%b opa=%h", req_ready, rsp_valid,
                     rsp_result, rsp_cpsr, busy, alu_opa);
        end
        step();
        rst = 1'b0;
        req_valid = '0;
        step();
    endtask

    task automatic one_op(string nm, int i, logic [3:0] a, logic [3:0] b, logic [1:0] c,
                          logic [1:0] want_v, logic [3:0] want_r, logic want_z);
        set_req(i, a, b, 2'b00, c, 2'b00);
        req_valid = 2'(1 << i);
        expect_ready(nm, 2'(1 << i));
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== want_v || rsp_result !== want_r || rsp_cpsr[0] !== want_z) begin
            n_fail++;
            $display("FAIL %s_rsp: valid=%b res=%h z=%b want %b %h %b", nm, rsp_valid, rsp_result, rsp_cpsr[0],
                     want_v, want_r, want_z);
        end
        step();
        step();
    endtask

    task automatic test_alu_ops();
        one_op("add0", 0, 4'd2, 4'd1, 2'b00, 2'b01, 4'd3, 1'b0);
        one_op("sub1_zero", 1, 4'd3, 4'd3, 2'b01, 2'b10, 4'd0, 1'b1);
        one_op("sub1", 1, 4'd3, 4'd1, 2'b01, 2'b10, 4'd2, 1'b0);
    endtask

    task automatic test_round_robin();
        do_reset();
        set_req(0, 4'd5, 4'd6, 2'b00, 2'b00, 2'b01);
        set_req(1, 4'd9, 4'd3, 2'b00, 2'b10, 2'b10);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            expect_ready($sformatf("rr_%0d", k), k % 2 == 0 ? 2'b01 : 2'b10);
            if (k > 0) begin
                n_chk++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rr_busy_%0d: busy=%b want 1", k, busy);
                end
            end
            step();
        end
        req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_wrap();
        do_reset();
        set_req(0, 4'd7, 4'd7, 2'b00, 2'b11, 2'b00);
        set_req(1, 4'd8, 4'd1, 2'b01, 2'b00, 2'b11);
        req_valid = 2'b10;
        for (int k = 0; k < 3; k++) begin
            expect_ready($sformatf("wrap_r1_%0d", k), 2'b10);
            step();
        end
        req_valid = 2'b11;
        expect_ready("wrap_r0", 2'b01);
        step();
        req_valid = '0;
        repeat (4) step();
    endtask

    task automatic test_flush();
        do_reset();
        set_req(0, 4'd4, 4'd4, 2'b00, 2'b00, 2'b01);
        req_valid = 2'b01;
        expect_ready("flush_xfer", 2'b01);
        step();
        req_valid = '0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_chk++;
            if (rsp_valid !== 2'b00 || busy !== 1'b0 || rsp_result !== 4'd0 || alu_opa !== 4'd0 || alu_kernelsel !== 2'd0) begin
                n_fail++;
                $display("FAIL flush_%0d: rsp=%b busy=%b res=%h opa=%h ks=%b", k, rsp_valid, busy, rsp_result,
                         alu_opa, alu_kernelsel);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 10; k++) begin
            for (int i = 0; i < 2; i++)
                set_req(i, 4'($urandom), 4'($urandom), 2'($urandom_range(0, 1)), 2'($urandom), 2'($urandom));
            req_valid = 2'($urandom_range(1, 3));
            step();
        end
        req_valid = '0;
        repeat (4) step();
    endtask

`ifdef ALU_ARB_LOCK_EN
    task automatic test_lock();
        logic [1:0] want [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
        do_reset();
        set_req(0, 4'd1, 4'd1, 2'b00, 2'b00, 2'b00);
        set_req(1, 4'd2, 4'd2, 2'b00, 2'b00, 2'b00);
        req_lock = 2'b01;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            expect_ready($sformatf("lock_%0d", k), want[k]);
            step();
        end
        req_valid = '0;
        req_lock = '0;
        repeat (4) step();
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_round_robin();
        test_wrap();
        test_flush();
        test_back_to_back();
`ifdef ALU_ARB_LOCK_EN
        test_lock();
`endif
        repeat (3) step();
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d responses outstanding, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
